// File: rtl/adder_chk_if.sv
// Operand/sum/result bundle between the adder checker and the block that drives it.
// The slave modport belongs to the checker; the master modport belongs to the stimulus side.
interface adder_chk_if #(
    parameter int NB_BITS = 16,
    parameter int NB_CNT  = 32
);
    logic                i_start;
    logic [NB_BITS-1:0]  i_a;
    logic [NB_BITS-1:0]  i_b;
    logic                i_cin;
    logic [NB_BITS:0]    i_sum_rca;
    logic [NB_BITS:0]    i_sum_bcla;
    logic [NB_BITS:0]    i_sum_hcsa;
    logic                o_busy;
    logic                o_done;
    logic                o_pass;
    logic [2:0]          o_err_vec;
    logic [NB_CNT-1:0]   o_sample_cnt;
    logic [NB_CNT-1:0]   o_err_cnt;
    logic [NB_CNT-1:0]   o_first_err_idx;

    modport master (
        output i_start, i_a, i_b, i_cin, i_sum_rca, i_sum_bcla, i_sum_hcsa,
        input  o_busy, o_done, o_pass, o_err_vec, o_sample_cnt, o_err_cnt, o_first_err_idx
    );

    modport slave (
        input  i_start, i_a, i_b, i_cin, i_sum_rca, i_sum_bcla, i_sum_hcsa,
        output o_busy, o_done, o_pass, o_err_vec, o_sample_cnt, o_err_cnt, o_first_err_idx
    );
endinterface

// File: rtl/adder_result_checker.sv
// Golden-sum checker for the three registered adders: delays the golden sum by LAT and counts mismatches.
// Optional feature macro ADDER_CHK_HALT_ON_ERR_EN: stop the run at the first mismatching compare.
module adder_result_checker #(
    parameter int NB_BITS   = 16,
    parameter int LAT       = 1,
    parameter int NB_CNT    = 32,
    parameter int N_SAMPLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    adder_chk_if.slave    bus
);
    localparam int NB_SUM = NB_BITS + 1;
    localparam logic [NB_CNT-1:0] CNT_MAX    = {NB_CNT{1'b1}};
    localparam logic [NB_CNT-1:0] CNT_ZERO   = {NB_CNT{1'b0}};
    localparam logic [NB_CNT-1:0] CNT_ONE    = NB_CNT'(1);
    localparam logic [NB_CNT-1:0] LAST_ISSUE = NB_CNT'(N_SAMPLES - 1);
    localparam logic [NB_CNT-1:0] LAST_DRAIN = NB_CNT'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [LAT-1:0]      r_dl_vld;
    logic [NB_SUM-1:0]   r_dl_gold [LAT];
    logic [NB_CNT-1:0]   r_issue_cnt;
    logic [NB_CNT-1:0]   r_drain_cnt;
    logic [NB_CNT-1:0]   r_sample_cnt;
    logic [NB_CNT-1:0]   r_err_cnt;
    logic [NB_CNT-1:0]   r_first_err_idx;
    logic [2:0]          r_err_vec;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic [NB_SUM-1:0]   w_gold;
    logic                w_cmp;
    logic [2:0]          w_mis;
    logic                w_any;
    logic                w_halt;
    logic [NB_CNT-1:0]   w_smp_nxt;
    logic [NB_CNT-1:0]   w_err_nxt;

    // Golden sum, per-adder compare against the delayed golden, saturating next counts
    always_comb begin
        w_gold = NB_SUM'(bus.i_a) + NB_SUM'(bus.i_b) + NB_SUM'(bus.i_cin);
        w_cmp  = r_dl_vld[LAT-1];
        w_mis  = 3'b000;
        if (w_cmp) begin
            w_mis[0] = (bus.i_sum_rca  != r_dl_gold[LAT-1]);
            w_mis[1] = (bus.i_sum_bcla != r_dl_gold[LAT-1]);
            w_mis[2] = (bus.i_sum_hcsa != r_dl_gold[LAT-1]);
        end else begin
            w_mis = 3'b000;
        end
        w_any = |w_mis;
        if (w_cmp && (r_sample_cnt != CNT_MAX)) begin
            w_smp_nxt = r_sample_cnt + CNT_ONE;
        end else begin
            w_smp_nxt = r_sample_cnt;
        end
        if (w_any && (r_err_cnt != CNT_MAX)) begin
            w_err_nxt = r_err_cnt + CNT_ONE;
        end else begin
            w_err_nxt = r_err_cnt;
        end
`ifdef ADDER_CHK_HALT_ON_ERR_EN
        w_halt = w_any;
`else
        w_halt = 1'b0;
`endif
    end

    // Golden delay line: one entry pushed per cycle, valid only while issuing
    always_ff @(posedge clk) begin
        if (rst || w_halt) begin
            r_dl_vld <= {LAT{1'b0}};
        end else begin
            r_dl_vld[0]  <= (r_state == S_RUN);
            r_dl_gold[0] <= w_gold;
            for (int i = 1; i < LAT; i++) begin
                r_dl_vld[i]  <= r_dl_vld[i-1];
                r_dl_gold[i] <= r_dl_gold[i-1];
            end
        end
    end

    // Run sequencing, result counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_issue_cnt     <= CNT_ZERO;
            r_drain_cnt     <= CNT_ZERO;
            r_sample_cnt    <= CNT_ZERO;
            r_err_cnt       <= CNT_ZERO;
            r_first_err_idx <= CNT_MAX;
            r_err_vec       <= 3'b000;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            if (w_cmp) begin
                r_sample_cnt <= w_smp_nxt;
                r_err_cnt    <= w_err_nxt;
                r_err_vec    <= r_err_vec | w_mis;
                // Error count only leaves zero on a mismatch, so zero marks "no error yet"
                if (w_any && (r_err_cnt == CNT_ZERO)) begin
                    r_first_err_idx <= r_sample_cnt;
                end
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        r_state         <= S_RUN;
                        r_issue_cnt     <= CNT_ZERO;
                        r_sample_cnt    <= CNT_ZERO;
                        r_err_cnt       <= CNT_ZERO;
                        r_first_err_idx <= CNT_MAX;
                        r_err_vec       <= 3'b000;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_issue_cnt <= r_issue_cnt + CNT_ONE;
                    if (w_halt) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                    end else if (r_issue_cnt == LAST_ISSUE) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= CNT_ZERO;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (w_halt || (r_drain_cnt == LAST_DRAIN)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == CNT_ZERO);
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy          = r_busy;
    assign bus.o_done          = r_done;
    assign bus.o_pass          = r_pass;
    assign bus.o_err_vec       = r_err_vec;
    assign bus.o_sample_cnt    = r_sample_cnt;
    assign bus.o_err_cnt       = r_err_cnt;
    assign bus.o_first_err_idx = r_first_err_idx;
endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized bench for adder_result_checker: registered adder models with fault injection and a
// run-level reference model that predicts every output from the edge count since start.
module tb_adder_result_checker;
    localparam int NB_BITS = 16;
    localparam int LAT     = 1;
    localparam int NB_CNT  = 32;
    localparam int N       = 8;
`ifdef ADDER_CHK_HALT_ON_ERR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_chk_if #(.NB_BITS(NB_BITS), .NB_CNT(NB_CNT)) bus ();

    adder_result_checker #(
        .NB_BITS(NB_BITS), .LAT(LAT), .NB_CNT(NB_CNT), .N_SAMPLES(N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;
    int op_mode = 0;

    // Stimulus-side fault plan for the next run; snapshotted by the model at the start edge
    logic [2:0] inj_vec [N];
    int         inj_pos [N];
    logic [2:0] m_vec [N];
    int         m_pos [N];
    bit         m_active = 1'b0;
    int         m_e = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int first_inj();
        for (int j = 0; j < N; j++) begin
            if (m_vec[j] != 3'b000) return j;
        end
        return -1;
    endfunction

    // Number of compares in the current run
    function automatic int n_stop();
        int h;
        h = first_inj();
        if (HALT && (h >= 0)) return h + 1;
        return N;
    endfunction

    function automatic int done_edge();
        return n_stop() + LAT;
    endfunction

    // Run model: edge count since the start edge that was honoured
    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
        end else if (bus.i_start && (!m_active || (m_e >= done_edge()))) begin
            m_active <= 1'b1;
            m_e      <= 0;
            m_vec    <= inj_vec;
            m_pos    <= inj_pos;
        end else if (m_active) begin
            m_e <= m_e + 1;
        end
    end

    // Registered adder models; the sample issued at edge j+1 may carry a planted bit flip
    logic [NB_BITS:0] gold_s, flip_s;
    logic [2:0]       vec_s;
    logic [NB_BITS:0] p_rca [LAT];
    logic [NB_BITS:0] p_bcla [LAT];
    logic [NB_BITS:0] p_hcsa [LAT];
    logic [NB_BITS:0] one_s;

    always_comb begin
        one_s  = {{NB_BITS{1'b0}}, 1'b1};
        gold_s = {1'b0, bus.i_a} + {1'b0, bus.i_b} + {{NB_BITS{1'b0}}, bus.i_cin};
        vec_s  = 3'b000;
        flip_s = {(NB_BITS+1){1'b0}};
        if (m_active && (m_e < N)) begin
            vec_s  = m_vec[m_e];
            flip_s = one_s << m_pos[m_e];
        end
    end

    always @(posedge clk) begin
        p_rca[0]  <= gold_s ^ (vec_s[0] ? flip_s : {(NB_BITS+1){1'b0}});
        p_bcla[0] <= gold_s ^ (vec_s[1] ? flip_s : {(NB_BITS+1){1'b0}});
        p_hcsa[0] <= gold_s ^ (vec_s[2] ? flip_s : {(NB_BITS+1){1'b0}});
        for (int i = 1; i < LAT; i++) begin
            p_rca[i]  <= p_rca[i-1];
            p_bcla[i] <= p_bcla[i-1];
            p_hcsa[i] <= p_hcsa[i-1];
        end
    end

    assign bus.i_sum_rca  = p_rca[LAT-1];
    assign bus.i_sum_bcla = p_bcla[LAT-1];
    assign bus.i_sum_hcsa = p_hcsa[LAT-1];

    // Per-cycle compare of every output against the run model
    logic              e_busy, e_done, e_pass;
    logic [2:0]        e_vec;
    logic [NB_CNT-1:0] e_smp, e_err, e_first;
    int                e_c;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_pass  = 1'b0;
            e_vec   = 3'b000;
            e_smp   = {NB_CNT{1'b0}};
            e_err   = {NB_CNT{1'b0}};
            e_first = {NB_CNT{1'b1}};
            if (m_active) begin
                e_c = m_e - LAT;
                if (e_c < 0) e_c = 0;
                if (e_c > n_stop()) e_c = n_stop();
                e_busy = (m_e < done_edge());
                e_done = !e_busy;
                e_smp  = NB_CNT'(e_c);
                for (int j = 0; j < e_c; j++) begin
                    if (m_vec[j] != 3'b000) begin
                        if (e_err == {NB_CNT{1'b0}}) e_first = NB_CNT'(j);
                        e_err = e_err + NB_CNT'(1);
                        e_vec = e_vec | m_vec[j];
                    end
                end
                e_pass = e_done && (e_err == {NB_CNT{1'b0}});
            end
            cmp("busy",      64'(bus.o_busy),          64'(e_busy));
            cmp("done",      64'(bus.o_done),          64'(e_done));
            cmp("pass",      64'(bus.o_pass),          64'(e_pass));
            cmp("err_vec",   64'(bus.o_err_vec),       64'(e_vec));
            cmp("sample_cnt",64'(bus.o_sample_cnt),    64'(e_smp));
            cmp("err_cnt",   64'(bus.o_err_cnt),       64'(e_err));
            cmp("first_idx", 64'(bus.o_first_err_idx), 64'(e_first));
        end
    end

    task automatic tick(input bit start);
        case (op_mode)
            1: begin bus.i_a = {NB_BITS{1'b1}}; bus.i_b = {NB_BITS{1'b1}}; bus.i_cin = 1'b1; end
            2: begin bus.i_a = {NB_BITS{1'b0}}; bus.i_b = {NB_BITS{1'b0}}; bus.i_cin = 1'b0; end
            3: begin
                bus.i_a   = ($urandom_range(0, 1) != 0) ? {NB_BITS{1'b1}} : {NB_BITS{1'b0}};
                bus.i_b   = ($urandom_range(0, 1) != 0) ? {NB_BITS{1'b1}} : {NB_BITS{1'b0}};
                bus.i_cin = 1'($urandom_range(0, 1));
            end
            default: begin
                bus.i_a = NB_BITS'($urandom); bus.i_b = NB_BITS'($urandom); bus.i_cin = 1'($urandom);
            end
        endcase
        bus.i_start = start;
        @(negedge clk);
    endtask

    task automatic clear_inj();
        for (int j = 0; j < N; j++) begin
            inj_vec[j] = 3'b000;
            inj_pos[j] = 0;
        end
    endtask

    task automatic run_full();
        tick(1'b1);
        repeat (N + LAT) tick(1'b0);
    endtask

    task automatic chk_clean(input string tag);
        cmp({tag, "_done"}, 64'(bus.o_done),       64'(1));
        cmp({tag, "_smp"},  64'(bus.o_sample_cnt), 64'(8));
        cmp({tag, "_err"},  64'(bus.o_err_cnt),    64'(0));
        cmp({tag, "_pass"}, 64'(bus.o_pass),       64'(1));
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_a = {NB_BITS{1'b0}};
        bus.i_b = {NB_BITS{1'b0}};
        bus.i_cin = 1'b0;
        clear_inj();
        @(negedge clk);
        repeat (3) tick(1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        cmp("rst_first", 64'(bus.o_first_err_idx), 64'(32'hFFFF_FFFF));
        cmp("rst_busy",  64'(bus.o_busy),          64'(0));

        // Ideal adders, random operands: done exactly 1+8+1 edges after the start pulse
        op_mode = 0;
        tick(1'b1);
        repeat (N) tick(1'b0);
        cmp("t2_done_early", 64'(bus.o_done), 64'(0));
        tick(1'b0);
        chk_clean("t2");

        // Restart from DONE with start pulses in RUN that must be ignored
        tick(1'b1);
        for (int k = 1; k <= N + LAT; k++) tick((k == 3) || (k == 6));
        chk_clean("t6");

        // Corner operands
        op_mode = 1; run_full(); chk_clean("t3_max");
        op_mode = 2; run_full(); chk_clean("t3_zero");
        op_mode = 3; run_full(); chk_clean("t3_mix");

        // bcla carry bit flipped on sample 5
        op_mode = 0;
        clear_inj(); inj_vec[5] = 3'b010; inj_pos[5] = 16;
        run_full();
        cmp("t4_vec",   64'(bus.o_err_vec),       64'(3'b010));
        cmp("t4_err",   64'(bus.o_err_cnt),       64'(1));
        cmp("t4_first", 64'(bus.o_first_err_idx), 64'(5));
        cmp("t4_pass",  64'(bus.o_pass),          64'(0));

        // Error at sample 2 of 8
        clear_inj(); inj_vec[2] = 3'b101; inj_pos[2] = int'($urandom_range(0, 16));
        tick(1'b1);
        repeat (3) tick(1'b0);
        cmp("t5_done_early", 64'(bus.o_done), 64'(0));
        tick(1'b0);
`ifdef ADDER_CHK_HALT_ON_ERR_EN
        cmp("t5_halt_done", 64'(bus.o_done),       64'(1));
        cmp("t5_halt_smp",  64'(bus.o_sample_cnt), 64'(3));
        repeat (N + LAT - 4) tick(1'b0);
        cmp("t5_halt_hold", 64'(bus.o_sample_cnt), 64'(3));
`else
        cmp("t5_run_done", 64'(bus.o_done), 64'(0));
        repeat (N + LAT - 4) tick(1'b0);
        cmp("t5_run_smp",  64'(bus.o_sample_cnt), 64'(8));
`endif
        cmp("t5_err",   64'(bus.o_err_cnt),       64'(1));
        cmp("t5_first", 64'(bus.o_first_err_idx), 64'(2));
        cmp("t5_vec",   64'(bus.o_err_vec),       64'(3'b101));

        // Random fault plans, checked by the per-cycle model only
        for (int r = 0; r < 12; r++) begin
            clear_inj();
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    inj_vec[j] = 3'($urandom_range(1, 7));
                    inj_pos[j] = int'($urandom_range(0, NB_BITS));
                end
            end
            op_mode = int'($urandom_range(0, 3));
            run_full();
        end

        // Reset held 3 cycles in the middle of a run that already saw an error
        op_mode = 0;
        clear_inj(); inj_vec[1] = 3'b001; inj_pos[1] = 0;
        tick(1'b1);
        repeat (4) tick(1'b0);
        cmp("t1_pre_err", 64'(bus.o_err_cnt), 64'(1));
        rst = 1'b1;
        repeat (3) tick(1'b0);
        rst = 1'b0;
        cmp("t1_busy",  64'(bus.o_busy),          64'(0));
        cmp("t1_done",  64'(bus.o_done),          64'(0));
        cmp("t1_smp",   64'(bus.o_sample_cnt),    64'(0));
        cmp("t1_err",   64'(bus.o_err_cnt),       64'(0));
        cmp("t1_vec",   64'(bus.o_err_vec),       64'(0));
        cmp("t1_first", 64'(bus.o_first_err_idx), 64'(32'hFFFF_FFFF));
        clear_inj();
        run_full();
        chk_clean("t1_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
